// File: rtl/sync0_qual_pkg.sv
// Shared types and helpers for the SYNC0 input qualifier.
package sync0_qual_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    typedef enum logic [1:0] {
        CLS_GOOD,
        CLS_EARLY,
        CLS_LATE
    } edge_class_t;

    function automatic int unsigned nom_period(input int unsigned clk_hz,
                                               input int unsigned sync_hz);
        return clk_hz / sync_hz;
    endfunction

    function automatic edge_class_t classify(input logic [15:0] p,
                                             input logic [15:0] lo,
                                             input logic [15:0] hi);
        if (p < lo)
            return CLS_EARLY;
        else if (p > hi)
            return CLS_LATE;
        else
            return CLS_GOOD;
    endfunction

endpackage

// File: rtl/sync0_qualifier_edge_det.sv
// 3-flop synchronizer with a registered rising-edge pulse.
module sync_edge_det #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic [2:0] sync_q;

    // Reset value high means a level already high at release is not an edge.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {3{RESET_VAL}};
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], d};
            pulse  <= (sync_q[2:1] == 2'b01);
        end
    end

endmodule

// File: rtl/sync0_qualifier.sv
// SYNC0 qualifier: re-times SYNC0, measures its period, rejects glitches
// once locked and reports lock, missed pulses and period errors.
module sync0_qualifier
    import sync0_qual_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 20480000,
    parameter int unsigned SYNC0_FREQ   = 2000,
    parameter int unsigned TOL          = 4,
    parameter int unsigned LOCK_CNT     = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        SYNC_IN,
    output logic        SYNC_OUT,
    output logic        LOCKED,
    output logic        MISSED,
    output logic [15:0] PERIOD,
    output logic [7:0]  ERR_CNT
);

    localparam int unsigned NOM_PERIOD  = nom_period(SYS_CLK_FREQ, SYNC0_FREQ);
    localparam logic [15:0] P_MIN       = 16'(NOM_PERIOD - TOL);
    localparam logic [15:0] P_MAX       = 16'(NOM_PERIOD + TOL);
    localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_CNT);

    logic        edge_pulse;
    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, period_nx, p_sat;
    logic [3:0]  good_cnt, good_nx;
    logic [7:0]  err_nx;
    logic        sync_nx, missed_nx, accept, err_inc, timeout;
    edge_class_t cls;

    sync_edge_det #(.RESET_VAL(1'b1)) u_edge_det (
        .sys_clk (CLK),
        .reset_n (RESET_N),
        .d       (SYNC_IN),
        .pulse   (edge_pulse)
    );

    // p_sat doubles as the saturating increment of the free-running counter.
    assign p_sat   = (cnt == 16'hFFFF) ? 16'hFFFF : cnt + 16'd1;
    assign cls     = classify(p_sat, P_MIN, P_MAX);
    assign timeout = (cnt == P_MAX);
    assign LOCKED  = (state == ST_LOCKED);

    always_comb begin
        state_nx  = state;
        cnt_nx    = p_sat;
        good_nx   = good_cnt;
        period_nx = PERIOD;
        missed_nx = 1'b0;
        accept    = 1'b0;
        err_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (edge_pulse) begin
                    accept   = 1'b1;
                    state_nx = ST_ACQUIRE;
                    good_nx  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (edge_pulse) begin
                    accept = 1'b1;
                    if (cls == CLS_GOOD) begin
                        good_nx = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_TARGET)
                            state_nx = ST_LOCKED;
                    end else begin
                        good_nx = '0;
                        err_inc = 1'b1;
                    end
                end else if (timeout) begin
                    missed_nx = 1'b1;
                    err_inc   = 1'b1;
                    good_nx   = '0;
                end
            end
            ST_LOCKED: begin
                if (edge_pulse) begin
                    case (cls)
                        CLS_GOOD:  accept = 1'b1;
                        CLS_EARLY: err_inc = 1'b1;
                        default: begin
                            accept   = 1'b1;
                            err_inc  = 1'b1;
                            state_nx = ST_ACQUIRE;
                            good_nx  = '0;
                        end
                    endcase
                end else if (timeout) begin
                    missed_nx = 1'b1;
                    err_inc   = 1'b1;
                    state_nx  = ST_ACQUIRE;
                    good_nx   = '0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        sync_nx = accept;
        if (accept) begin
            period_nx = p_sat;
            cnt_nx    = '0;
        end
        err_nx = (err_inc && ERR_CNT != 8'hFF) ? ERR_CNT + 8'd1 : ERR_CNT;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            good_cnt <= '0;
            PERIOD   <= '0;
            ERR_CNT  <= '0;
            SYNC_OUT <= 1'b0;
            MISSED   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            good_cnt <= good_nx;
            PERIOD   <= period_nx;
            ERR_CNT  <= err_nx;
            SYNC_OUT <= sync_nx;
            MISSED   <= missed_nx;
        end
    end

endmodule

// File: tb/tb_sync0_qualifier.sv
// Randomized bench for sync0_qualifier against an edge-timestamp reference model.
module tb_sync0_qualifier;

    localparam int SYS_HZ  = 400000;
    localparam int SYNC_HZ = 2000;
    localparam int NOM     = SYS_HZ / SYNC_HZ;
    localparam int TOL     = 4;
    localparam int LOCKN   = 4;
    localparam int W       = 10;
    localparam int LAT     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_in = 1'b1;
    logic        sync_out, locked, missed;
    logic [15:0] period;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    sync0_qualifier #(
        .SYS_CLK_FREQ (SYS_HZ),
        .SYNC0_FREQ   (SYNC_HZ),
        .TOL          (TOL),
        .LOCK_CNT     (LOCKN)
    ) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .SYNC_IN  (sync_in),
        .SYNC_OUT (sync_out),
        .LOCKED   (locked),
        .MISSED   (missed),
        .PERIOD   (period),
        .ERR_CNT  (err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit so;
        bit ms;
        bit lk;
        int err;
        int per;
        bit pk;
    } exp_t;

    exp_t   q[$];
    bit     m_active, m_locked, m_pknown, prev_s;
    int     m_good, m_err, m_period;
    longint t = 0;
    longint t0 = 0;

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        exp_t e;
        m_active = 0; m_locked = 0; m_pknown = 1; m_good = 0;
        m_err = 0; m_period = 0; prev_s = 1;
        e.so = 0; e.ms = 0; e.lk = 0; e.err = 0; e.per = 0; e.pk = 1;
        q.delete();
        repeat (LAT) q.push_back(e);
    endtask

    // Works on sampled-input timestamps; period = time since last accepted rise.
    task automatic model_step(input bit s);
        exp_t   e;
        bit     rise, good_p, early;
        longint p;
        t++;
        rise = s && !prev_s;
        prev_s = s;
        e.so = 0; e.ms = 0;
        p = t - t0;
        if (p > 65535) p = 65535;
        good_p = (p >= NOM - TOL) && (p <= NOM + TOL);
        early  = (p < NOM - TOL);
        if (rise) begin
            if (!m_active) begin
                m_active = 1; m_good = 0; t0 = t; e.so = 1; m_pknown = 0;
            end else if (!m_locked || good_p || !early) begin
                e.so = 1; t0 = t; m_period = int'(p); m_pknown = 1;
                if (good_p) begin
                    if (!m_locked) begin
                        m_good++;
                        if (m_good == LOCKN) m_locked = 1;
                    end
                end else begin
                    bump_err();
                    m_locked = 0;
                    m_good = 0;
                end
            end else begin
                bump_err();
            end
        end else if (m_active && p == NOM + TOL + 1) begin
            e.ms = 1; bump_err(); m_locked = 0; m_good = 0;
        end
        e.lk = m_locked; e.err = m_err; e.per = m_period; e.pk = m_pknown;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive_cycle(input bit s);
        exp_t e;
        sync_in = s;
        @(posedge clk);
        model_step(s);
        #1;
        e = q.pop_front();
        check("sync_out", {31'd0, sync_out}, {31'd0, e.so});
        check("missed",   {31'd0, missed},   {31'd0, e.ms});
        check("locked",   {31'd0, locked},   {31'd0, e.lk});
        check("err_cnt",  {24'd0, err_cnt},  e.err);
        if (e.pk) check("period", {16'd0, period}, e.per);
        @(negedge clk);
    endtask

    task automatic hold(input bit s, input int n);
        repeat (n) drive_cycle(s);
    endtask

    task automatic edge_gap(input int gap);
        hold(1'b1, W);
        hold(1'b0, gap - W);
    endtask

    task automatic edge_glitch(input int gap, input int off);
        hold(1'b1, W);
        hold(1'b0, off - W);
        hold(1'b1, 2);
        hold(1'b0, gap - off - 2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sync_out"}, {31'd0, sync_out}, 0);
        check({tag, "_missed"},   {31'd0, missed},   0);
        check({tag, "_locked"},   {31'd0, locked},   0);
        check({tag, "_period"},   {16'd0, period},   0);
        check({tag, "_err_cnt"},  {24'd0, err_cnt},  0);
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        sync_in = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        model_reset();

        hold(1'b1, 20);
        hold(1'b0, 30);

        repeat (6) edge_gap(NOM);
        check("lock_locked", {31'd0, locked}, 1);
        check("lock_err", {24'd0, err_cnt}, 0);
        check("lock_period", {16'd0, period}, NOM);

        edge_gap(NOM - TOL);
        edge_gap(NOM + TOL);
        edge_gap(NOM + TOL + 1);
        edge_gap(NOM);
        check("bound_locked", {31'd0, locked}, 0);
        check("bound_err", {24'd0, err_cnt}, 1);

        repeat (5) edge_gap(NOM);
        edge_glitch(NOM, 60);
        edge_gap(NOM);
        check("glitch_locked", {31'd0, locked}, 1);
        check("glitch_period", {16'd0, period}, NOM);
        check("glitch_err", {24'd0, err_cnt}, 2);

        hold(1'b0, 2 * NOM + 50);
        check("miss_locked", {31'd0, locked}, 0);
        check("miss_err", {24'd0, err_cnt}, 3);

        edge_gap(NOM);
        edge_gap(NOM);
        edge_gap(NOM + TOL + 1);
        edge_gap(NOM);
        check("tmo_edge_err", {24'd0, err_cnt}, 5);
        check("tmo_edge_period", {16'd0, period}, NOM + TOL + 1);

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0, 1: edge_gap(NOM - TOL + int'($urandom_range(0, 2 * TOL)));
                2:    edge_gap(int'($urandom_range(30, NOM - TOL - 1)));
                3:    edge_gap(int'($urandom_range(NOM + TOL + 1, NOM + TOL + 30)));
                4:    edge_glitch(NOM, int'($urandom_range(20, NOM - 40)));
                default: edge_gap(int'($urandom_range(NOM + TOL + 30, 3 * NOM)));
            endcase
        end

        repeat (7) edge_gap(NOM);
        check("relock_locked", {31'd0, locked}, 1);
        hold(1'b1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        sync_in = 1'b0;
        rst_n = 1'b1;
        model_reset();
        hold(1'b0, 20);
        repeat (3) edge_gap(NOM);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
